// File: rtl/mandel_iter_engine.sv
// Mandelbrot escape-time engine: iterates z <- z^2 + c in signed fixed point, one step per clk.
// Optional MANDEL_CARDIOID_EN: main-cardioid / period-2-bulb bypass that skips iteration for interior points.
module mandel_iter_engine #(
  parameter int WIDTH  = 27,
  parameter int FRAC   = 23,
  parameter int ITER_W = 13
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              in_valid,
  output logic              in_ready,
  input  logic [WIDTH-1:0]  cr,
  input  logic [WIDTH-1:0]  ci,
  input  logic [ITER_W-1:0] in_max_iter,
  output logic              out_valid,
  input  logic              out_ready,
  output logic [ITER_W-1:0] out_iter,
  output logic              out_escaped,
  output logic              busy
);
  localparam int PW = 2*WIDTH;
  // 4.0 at the 2*FRAC scale of a full-width square
  localparam logic [PW:0] ESC_LIMIT = {{(PW-2*FRAC-2){1'b0}}, 1'b1, {(2*FRAC+2){1'b0}}};

  typedef enum logic [1:0] {IDLE, ITER, DONE} state_t;
  state_t state;

  logic signed [WIDTH-1:0] zr, zi, cr_q, ci_q, zr_next, zi_next;
  logic [ITER_W-1:0]       k, max_q;
  logic signed [PW-1:0]    zr_w, zi_w, zr_sq, zi_sq, zr_zi;
  logic [PW:0]             mag;
  logic                    bypass;

  assign zr_w    = {{WIDTH{zr[WIDTH-1]}}, zr};
  assign zi_w    = {{WIDTH{zi[WIDTH-1]}}, zi};
  assign zr_sq   = zr_w * zr_w;
  assign zi_sq   = zi_w * zi_w;
  assign zr_zi   = zr_w * zi_w;
  assign mag     = {1'b0, zr_sq} + {1'b0, zi_sq};
  // Each product is floored to the z format on its own before combining
  assign zr_next = WIDTH'(zr_sq >>> FRAC) - WIDTH'(zi_sq >>> FRAC) + cr_q;
  assign zi_next = WIDTH'((zr_zi >>> FRAC) <<< 1) + ci_q;

`ifdef MANDEL_CARDIOID_EN
  localparam int QW = 2*WIDTH + 4;
  localparam int LW = 2*QW;
  localparam logic signed [WIDTH+1:0] QUARTER   = {{(WIDTH+3-FRAC){1'b0}}, 1'b1, {(FRAC-2){1'b0}}};
  localparam logic signed [WIDTH+1:0] ONE       = {{(WIDTH+1-FRAC){1'b0}}, 1'b1, {FRAC{1'b0}}};
  localparam logic signed [QW-1:0]    SIXTEENTH = {{(QW-2*FRAC+3){1'b0}}, 1'b1, {(2*FRAC-4){1'b0}}};

  logic signed [WIDTH+1:0] cr_e, xs, ys;
  logic signed [QW-1:0]    xs_w, ys_w, ci_w, x_sq, y_sq, ci_sq, q, q_px;
  logic signed [LW-1:0]    q_l, q_px_l, lhs, rhs;

  assign cr_e   = {{2{cr[WIDTH-1]}}, cr};
  assign xs     = cr_e - QUARTER;
  assign ys     = cr_e + ONE;
  assign xs_w   = {{(QW-WIDTH-2){xs[WIDTH+1]}}, xs};
  assign ys_w   = {{(QW-WIDTH-2){ys[WIDTH+1]}}, ys};
  assign ci_w   = {{(QW-WIDTH){ci[WIDTH-1]}}, ci};
  assign x_sq   = xs_w * xs_w;
  assign y_sq   = ys_w * ys_w;
  assign ci_sq  = ci_w * ci_w;
  assign q      = x_sq + ci_sq;
  assign q_px   = q + (xs_w <<< FRAC);
  assign q_l    = {{QW{q[QW-1]}}, q};
  assign q_px_l = {{QW{q_px[QW-1]}}, q_px};
  // Both sides of the cardioid test live at the 4*FRAC scale, so no precision is lost
  assign lhs    = q_l * q_px_l;
  assign rhs    = {{QW{ci_sq[QW-1]}}, ci_sq} <<< (2*FRAC-2);
  assign bypass = (lhs <= rhs) || ((y_sq + ci_sq) <= SIXTEENTH);
`else
  assign bypass = 1'b0;
`endif

  always_ff @(posedge clk) begin
    if (reset) begin
      state       <= IDLE;
      in_ready    <= 1'b1;
      out_valid   <= 1'b0;
      out_iter    <= '0;
      out_escaped <= 1'b0;
      busy        <= 1'b0;
      zr          <= '0;
      zi          <= '0;
      cr_q        <= '0;
      ci_q        <= '0;
      k           <= '0;
      max_q       <= '0;
    end else begin
      case (state)
        IDLE: begin
          if (in_valid) begin
            cr_q     <= cr;
            ci_q     <= ci;
            max_q    <= in_max_iter;
            zr       <= '0;
            zi       <= '0;
            k        <= '0;
            in_ready <= 1'b0;
            if (bypass) begin
              out_iter    <= in_max_iter;
              out_escaped <= 1'b0;
              out_valid   <= 1'b1;
              state       <= DONE;
            end else begin
              busy  <= 1'b1;
              state <= ITER;
            end
          end
        end
        ITER: begin
          if (mag > ESC_LIMIT) begin
            out_iter    <= k;
            out_escaped <= 1'b1;
            out_valid   <= 1'b1;
            busy        <= 1'b0;
            state       <= DONE;
          end else if (k == max_q) begin
            out_iter    <= max_q;
            out_escaped <= 1'b0;
            out_valid   <= 1'b1;
            busy        <= 1'b0;
            state       <= DONE;
          end else begin
            zr <= zr_next;
            zi <= zi_next;
            k  <= k + 1'b1;
          end
        end
        DONE: begin
          if (out_ready) begin
            out_valid <= 1'b0;
            in_ready  <= 1'b1;
            state     <= IDLE;
          end
        end
        default: state <= IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_mandel_iter_engine.sv
// Scoreboard bench for mandel_iter_engine: stimulus pushes expected results, a monitor pops them on each output handshake.
module tb_mandel_iter_engine;
  localparam int WIDTH  = 27;
  localparam int FRAC   = 23;
  localparam int ITER_W = 13;
  localparam longint ONE = 64'sd1 << FRAC;
`ifdef MANDEL_CARDIOID_EN
  localparam bit BYPASS = 1'b1;
`else
  localparam bit BYPASS = 1'b0;
`endif

  logic              clk = 1'b0;
  logic              reset;
  logic              in_valid;
  logic              in_ready;
  logic [WIDTH-1:0]  cr;
  logic [WIDTH-1:0]  ci;
  logic [ITER_W-1:0] in_max_iter;
  logic              out_valid;
  logic              out_ready;
  logic [ITER_W-1:0] out_iter;
  logic              out_escaped;
  logic              busy;

  typedef struct packed {
    logic [ITER_W-1:0] iter;
    logic              esc;
  } result_t;

  result_t exp_q[$];
  result_t mon_exp;
  int total = 0;
  int bad   = 0;

  longint t6_re[4] = '{-(3*ONE)/4, ONE/2, 64'sd2516582, -(3*ONE)/2};
  longint t6_im[4] = '{64'sd838861, ONE/2, -ONE/2, 64'sd0};

  always #5 clk = ~clk;

  mandel_iter_engine #(.WIDTH(WIDTH), .FRAC(FRAC), .ITER_W(ITER_W)) dut (
    .clk(clk), .reset(reset), .in_valid(in_valid), .in_ready(in_ready),
    .cr(cr), .ci(ci), .in_max_iter(in_max_iter),
    .out_valid(out_valid), .out_ready(out_ready), .out_iter(out_iter),
    .out_escaped(out_escaped), .busy(busy)
  );

  function automatic result_t mk(input int it, input bit e);
    result_t r;
    r.iter = ITER_W'(it);
    r.esc  = e;
    return r;
  endfunction

  // Software reference: 64-bit integers, each product floored by an arithmetic shift
  function automatic result_t model(input longint c_re, input longint c_im, input int nmax);
    longint zr = 0;
    longint zi = 0;
    longint t;
    result_t r;
    r = mk(nmax, 1'b0);
    for (int k = 0; k <= nmax; k++) begin
      if (zr*zr + zi*zi > (64'sd4 << (2*FRAC))) return mk(k, 1'b1);
      t  = ((zr*zr) >>> FRAC) - ((zi*zi) >>> FRAC) + c_re;
      zi = 2*((zr*zi) >>> FRAC) + c_im;
      zr = t;
    end
    return r;
  endfunction

  task automatic checkOutput(input string name, input longint actual, input longint expected);
    total++;
    if (actual != expected) begin
      bad++;
      $display("[TB] FAIL %s: got %0d expected %0d", name, actual, expected);
    end
  endtask

  task automatic applyStimulus(input longint c_re, input longint c_im, input int nmax, input result_t expv);
    int waited = 0;
    while (!in_ready && waited < 3000) begin
      @(posedge clk); #1;
      waited++;
    end
    if (!in_ready) checkOutput("in_ready_wait", in_ready, 1);
    cr          = WIDTH'(c_re);
    ci          = WIDTH'(c_im);
    in_max_iter = ITER_W'(nmax);
    in_valid    = 1'b1;
    @(posedge clk); #1;
    exp_q.push_back(expv);
    in_valid    = 1'b0;
    cr          = WIDTH'($urandom);
    ci          = WIDTH'($urandom);
    in_max_iter = ITER_W'($urandom);
  endtask

  task automatic waitOutValid(input string name, input int exp_edges);
    int n = 0;
    do begin
      @(posedge clk); #1;
      n++;
    end while (!out_valid && n < 3000);
    checkOutput(name, n, exp_edges);
  endtask

  // Monitor: every output handshake consumes one scoreboard entry
  always @(negedge clk) begin
    if (!reset && out_valid && out_ready) begin
      if (exp_q.size() == 0) begin
        total++;
        bad++;
        $display("[TB] FAIL unexpected_result: got iter=%0d esc=%0d expected no result", out_iter, out_escaped);
      end else begin
        mon_exp = exp_q.pop_front();
        checkOutput("result_iter", out_iter, mon_exp.iter);
        checkOutput("result_escaped", out_escaped, mon_exp.esc);
      end
    end
  end

  initial begin
    #2_000_000;
    $display("[TB] FAIL watchdog: got timeout expected completion");
    $fatal(1, "[TB] watchdog expired");
  end

  initial begin
    int waited;
    reset       = 1'b1;
    in_valid    = 1'b0;
    cr          = '0;
    ci          = '0;
    in_max_iter = '0;
    out_ready   = 1'b1;
    repeat (3) @(posedge clk);
    #1;
    checkOutput("reset_in_ready", in_ready, 1);
    checkOutput("reset_out_valid", out_valid, 0);
    checkOutput("reset_out_iter", out_iter, 0);
    checkOutput("reset_out_escaped", out_escaped, 0);
    checkOutput("reset_busy", busy, 0);
    reset = 1'b0;

    $display("[TB] T1 c=0 N=1000");
    applyStimulus(0, 0, 1000, mk(1000, 1'b0));
    checkOutput("t1_busy", busy, BYPASS ? 0 : 1);
    checkOutput("t1_in_ready_low", in_ready, 0);
    waitOutValid("t1_latency", BYPASS ? 1 : 1001);

    $display("[TB] T2 c=2.0");
    applyStimulus(2*ONE, 0, 1000, mk(2, 1'b1));
    waitOutValid("t2_latency", 3);

    $display("[TB] T3 c=+1.0 / -1.0");
    applyStimulus(ONE, 0, 1000, mk(3, 1'b1));
    waitOutValid("t3a_latency", 4);
    applyStimulus(-ONE, 0, 1000, mk(1000, 1'b0));
    waitOutValid("t3b_latency", BYPASS ? 1 : 1001);

    $display("[TB] T4 N=0 with stalled output");
    applyStimulus(ONE/2, ONE/2, 0, mk(0, 1'b0));
    out_ready = 1'b0;
    waitOutValid("t4_latency", 1);
    for (int i = 0; i < 10; i++) begin
      @(posedge clk); #1;
      checkOutput("t4_hold_valid", out_valid, 1);
      checkOutput("t4_hold_iter", out_iter, 0);
      checkOutput("t4_hold_escaped", out_escaped, 0);
      checkOutput("t4_hold_in_ready", in_ready, 0);
    end
    out_ready = 1'b1;

    $display("[TB] T5 reset mid-iteration");
    applyStimulus(0, 0, 1000, mk(1000, 1'b0));
    out_ready = 1'b0;
    repeat (500) @(posedge clk);
    #1;
    checkOutput("t5_busy_before", busy, BYPASS ? 0 : 1);
    reset = 1'b1;
    exp_q.delete();
    @(posedge clk); #1;
    checkOutput("t5_out_valid", out_valid, 0);
    checkOutput("t5_in_ready", in_ready, 1);
    checkOutput("t5_busy", busy, 0);
    reset     = 1'b0;
    out_ready = 1'b1;
    applyStimulus(2*ONE, 0, 1000, mk(2, 1'b1));
    waitOutValid("t5_latency", 3);

    $display("[TB] T6 back-to-back with in_valid held");
    for (int p = 0; p < 4; p++) begin
      cr          = WIDTH'(t6_re[p]);
      ci          = WIDTH'(t6_im[p]);
      in_max_iter = ITER_W'(200);
      in_valid    = 1'b1;
      waited      = 0;
      while (!in_ready && waited < 3000) begin
        @(posedge clk); #1;
        waited++;
      end
      if (!in_ready) checkOutput("t6_in_ready_wait", in_ready, 1);
      @(posedge clk); #1;
      exp_q.push_back(model(t6_re[p], t6_im[p], 200));
      checkOutput($sformatf("t6_no_reaccept_%0d", p), in_ready, 0);
    end
    in_valid = 1'b0;
    waited   = 0;
    while (exp_q.size() != 0 && waited < 3000) begin
      @(posedge clk); #1;
      waited++;
    end
    repeat (3) @(posedge clk);
    #1;
    checkOutput("t6_drained", exp_q.size(), 0);
    checkOutput("t6_idle_in_ready", in_ready, 1);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
